// File: rtl/led_blink_pkg.sv
// Shared constants and a bench helper for the Nexys A7 LED blink design.
`timescale 1ns/1ps
package led_blink_pkg;

    localparam int unsigned CLK_HZ_DEFAULT   = 100_000_000;
    localparam int unsigned TICK_DIV_DEFAULT = 25_000;
    localparam int unsigned LED_W_DEFAULT    = 16;

    // Number of whole ticks elapsed after a given number of microseconds.
    function automatic int unsigned ticks_for_us(
        input int unsigned us,
        input int unsigned clk_hz   = CLK_HZ_DEFAULT,
        input int unsigned tick_div = TICK_DIV_DEFAULT
    );
        longint unsigned cycles;
        cycles = 64'(us) * 64'(clk_hz) / 64'd1_000_000;
        return 32'(cycles / 64'(tick_div));
    endfunction

endpackage

// File: rtl/led_blink_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the 2nd clock edge.
`timescale 1ns/1ps
module reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_n_sync <= meta;
        end
    end

endmodule

// File: rtl/led_blink_top.sv
// Board top: prescaler tick drives a free-running counter shown on the LEDs.
`timescale 1ns/1ps
module led_blink_top
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned LED_W    = LED_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    output logic [LED_W-1:0] LED
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    // A tick period longer than one second of board clock means a mis-set divider.
    if (TICK_DIV < 2 || CLK_HZ < TICK_DIV) begin : g_param_check
        $error("led_blink_top: TICK_DIV out of range");
    end

    logic             rst_n_sync;
    logic [CNT_W-1:0] cnt;
    logic             tick_c;

    reset_sync u_reset_sync (
        .clk        (CLK),
        .rst_n      (CPU_RESETN),
        .rst_n_sync (rst_n_sync)
    );

    assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The LED register is the tick counter itself; it wraps silently.
    always_ff @(posedge CLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            LED <= '0;
        end else if (tick_c) begin
            LED <= LED + LED_W'(1);
        end
    end

endmodule

// File: tb/tb_led_blink_top.sv
// Directed bench for led_blink_top: default divider plus small-divider variants.
`timescale 1ns/1ps
module tb_led_blink_top;
    import led_blink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_def = 1'b0;
    logic        rst_d4  = 1'b0;
    logic        rst_d2  = 1'b0;
    logic        rst_w   = 1'b0;
    logic [15:0] led_def;
    logic [15:0] led_d4;
    logic [15:0] led_d2;
    logic [11:0] led_w;

    int n_tests = 0;
    int n_fail  = 0;

    // Rising edges at 5 + 10n ns.
    always #5 clk = ~clk;

    led_blink_top u_def (.CLK(clk), .CPU_RESETN(rst_def), .LED(led_def));
    led_blink_top #(.TICK_DIV(4)) u_d4 (.CLK(clk), .CPU_RESETN(rst_d4), .LED(led_d4));
    led_blink_top #(.TICK_DIV(2)) u_d2 (.CLK(clk), .CPU_RESETN(rst_d2), .LED(led_d2));
    led_blink_top #(.TICK_DIV(4), .LED_W(12)) u_w (.CLK(clk), .CPU_RESETN(rst_w), .LED(led_w));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic at(input time t);
        #(t - $time);
    endtask

    initial begin
        // Reset state on every instance.
        at(50);
        check("rst_def", 32'(led_def), 32'h0);
        check("rst_d4",  32'(led_d4),  32'h0);
        check("rst_d2",  32'(led_d2),  32'h0);
        check("rst_w",   32'(led_w),   32'h0);

        at(100);
        rst_def = 1'b1;
        rst_d4  = 1'b1;
        rst_w   = 1'b1;

        // Glitchy release: one edge seen at 105, re-asserted before 115.
        at(102);
        rst_d2 = 1'b1;
        at(108);
        rst_d2 = 1'b0;

        // d4: sync release at 115, LED=k from 115+40k.
        at(150);
        check("d4_step0", 32'(led_d4), 32'd0);
        at(160);
        check("d4_step1", 32'(led_d4), 32'd1);
        at(200);
        check("d4_step2", 32'(led_d4), 32'd2);

        // Sub-cycle reset pulse mid-count clears at once.
        at(201);
        rst_d4 = 1'b0;
        at(203);
        check("d4_pulse_clear", 32'(led_d4), 32'd0);
        at(204);
        rst_d4 = 1'b1;
        // Release re-timed to 215; first tick at 255.
        at(250);
        check("d4_restart_hold", 32'(led_d4), 32'd0);
        at(260);
        check("d4_restart_tick", 32'(led_d4), 32'd1);

        at(300);
        check("d2_glitch_led", 32'(led_d2), 32'd0);
        check("d2_glitch_cnt", 32'(u_d2.cnt), 32'd0);

        // d2: clean release, sync at 415, LED=k from 415+20k.
        at(400);
        rst_d2 = 1'b1;
        for (int t = 420; t <= 600; t += 10) begin
            at(time'(t));
            check("d2_step", 32'(led_d2), 32'((t - 415) / 20));
        end

        at(1100);
        check("d4_run", 32'(led_d4), 32'd22);
        check("def_hold_early", 32'(led_def), 32'd0);

        // 12-bit counter wraps FFF -> 000 at 163955.
        at(163950);
        check("w_full", 32'(led_w), 32'h0FFF);
        at(163960);
        check("w_wrap", 32'(led_w), 32'h0000);
        at(164000);
        check("w_after_wrap", 32'(led_w), 32'h0001);

        // Default divider: first LED[0] rise at 250_115 ns.
        at(250110);
        check("def_before_first", 32'(led_def), 32'h0);
        at(250120);
        check("def_first", 32'(led_def), 32'h1);
        at(375000);
        check("def_mid", 32'(led_def), ticks_for_us(375));
        at(500110);
        check("def_before_second", 32'(led_def), 32'h1);
        at(500120);
        check("def_second", 32'(led_def), ticks_for_us(500));
        check("def_led1", 32'(led_def[1]), 32'd1);
        check("d2_still_running", 32'(led_d2 != 16'h0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
